// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Registers an adder result together with its {N, Z, C, V} condition flags
// behind a ready/valid handshake. Storage is a 2-entry skid buffer: the main
// register drives the outputs and the skid register absorbs one extra beat,
// so in_ready depends only on registered state (no out_ready -> in_ready
// combinational path). Latency is one cycle when the stage is empty.
//
// Optional feature macro: ALU_RESULT_OVF_EN
//   defined   : V = (a_msb == b_msb) && (sum[N-1] != a_msb)
//   undefined : V = 0, a_msb/b_msb unused
//
// Parameters:
//   N         result width in bits (1..64)
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_valid  upstream adder result valid
//   in_ready  stage can accept a beat this cycle
//   sum       adder sum [N-1:0]
//   co        adder carry-out
//   a_msb     MSB of operand a
//   b_msb     MSB of operand b as applied to the adder
//   out_valid registered result valid
//   out_ready downstream accepts
//   result    registered sum [N-1:0]
//   flags     {N, Z, C, V} for result
// ---------------------------------------------------------------------------
module alu_result_stage #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] sum,
  input  logic         co,
  input  logic         a_msb,
  input  logic         b_msb,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  // One stored beat = {sum, N, Z, C, V}
  localparam int W = N + 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   main_reg, skid_reg;
  logic [W-1:0]   beat_in;
  logic           accept, deliver;
  logic           flag_n, flag_z, flag_v;

  // Flags are computed from the incoming beat and stored with it, so the
  // outputs are pure register reads.
  assign flag_n = sum[N-1];
  assign flag_z = (sum == '0);

`ifdef ALU_RESULT_OVF_EN
  // Signed overflow: operands share a sign and the sum's sign differs.
  assign flag_v = (a_msb == b_msb) && (sum[N-1] != a_msb);
`else
  logic unused_ovf_inputs;
  assign unused_ovf_inputs = a_msb ^ b_msb;
  assign flag_v = 1'b0;
`endif

  assign beat_in = {sum, flag_n, flag_z, co, flag_v};

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: begin
        if (accept) state_next = ONE;
      end
      ONE: begin
        if (accept && !deliver)      state_next = FULL;
        else if (!accept && deliver) state_next = EMPTY;
      end
      FULL: begin
        // in_ready is low here, so only a delivery can happen
        if (deliver) state_next = ONE;
      end
      default: state_next = EMPTY;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_reg)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  // Data path: main register feeds the outputs, skid holds the second beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) main_reg <= beat_in;
        end
        ONE: begin
          // With a simultaneous delivery the new beat replaces main directly;
          // otherwise it parks in the skid slot behind the stalled head.
          if (accept && deliver) main_reg <= beat_in;
          else if (accept)       skid_reg <= beat_in;
        end
        FULL: begin
          if (deliver) main_reg <= skid_reg;
        end
        default: begin
          main_reg <= main_reg;
        end
      endcase
    end
  end

  assign result = main_reg[W-1:4];
  assign flags  = main_reg[3:0];

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
//
// Bench for alu_result_stage with N = 4. Directed table of single beats,
// hand-written stall / streaming / mid-operation reset sequences and a long
// random run, all checked against a reference queue of expected beats.
// Works with or without ALU_RESULT_OVF_EN defined.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

  localparam int NW = 4;

`ifdef ALU_RESULT_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] sum;
  logic          co;
  logic          a_msb;
  logic          b_msb;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] result;
  logic [3:0]    flags;

  alu_result_stage #(.N(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .co        (co),
    .a_msb     (a_msb),
    .b_msb     (b_msb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;
  bit accepted;
  int max_depth = 0;
  logic [7:0] sb_q[$];   // {result, flags}

  typedef struct {
    logic [3:0] sum;
    logic       co;
    logic       a;
    logic       b;
    logic [3:0] exp_result;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference flag model for N = 4
  function automatic logic [3:0] exp_flags(input logic [3:0] s, input logic c,
                                           input logic a, input logic b);
    logic v;
    v = 1'b0;
    if (OVF) v = (a == b) && (s[3] != a);
    return {s[3], (s == 4'h0), c, v};
  endfunction

  // One clock of scoreboard bookkeeping. Inputs are already driven; the
  // handshake is evaluated on the falling edge, then the rising edge is taken.
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    chk("in_ready", in_ready, (sb_q.size() < 2));
    chk("out_valid", out_valid, (sb_q.size() != 0));
    accepted = 1'b0;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("spurious_beat", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_result", result, e[7:4]);
        chk("sb_flags", flags, e[3:0]);
        if (verbose) $display("beat out: result=%0h flags=%b", result, flags);
      end
    end
    if (in_valid && in_ready) begin
      sb_q.push_back({sum, exp_flags(sum, co, a_msb, b_msb)});
      accepted = 1'b1;
      if (verbose) $display("beat in : sum=%0h co=%b a_msb=%b b_msb=%b", sum, co, a_msb, b_msb);
    end
    if (sb_q.size() > max_depth) max_depth = sb_q.size();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", sb_q.size(), 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0110};
    vecs[1] = '{4'h8, 1'b0, 1'b0, 1'b0, 4'h8, {3'b100, OVF}};
    vecs[2] = '{4'h7, 1'b0, 1'b0, 1'b0, 4'h7, 4'b0000};
    vecs[3] = '{4'h7, 1'b1, 1'b1, 1'b1, 4'h7, {3'b001, OVF}};
    vecs[4] = '{4'hF, 1'b1, 1'b1, 1'b0, 4'hF, 4'b1010};
    vecs[5] = '{4'h0, 1'b0, 1'b1, 1'b1, 4'h0, {3'b010, OVF}};
    vecs[6] = '{4'h5, 1'b0, 1'b1, 1'b0, 4'h5, 4'b0000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sum = 4'hA; co = 1'b1; a_msb = 1'b1; b_msb = 1'b0;

    // Reset state, asserted before any clock edge
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table: one beat each from EMPTY, expect it one cycle later
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; sum = vecs[i].sum; co = vecs[i].co;
      a_msb = vecs[i].a; b_msb = vecs[i].b;
      @(posedge clk); #1;
      // Garbage on the data inputs while in_valid is low must be ignored
      in_valid = 1'b0; sum = 4'($urandom); co = 1'($urandom);
      a_msb = 1'($urandom); b_msb = 1'($urandom);
      chk("vec_out_valid", out_valid, 1);
      chk("vec_result", result, vecs[i].exp_result);
      chk("vec_flags", flags, vecs[i].exp_flags);
      chk("vec_in_ready", in_ready, 1);
      $display("vector %0d: sum=%0h result=%0h flags=%b", i, vecs[i].sum, result, flags);
      @(posedge clk); #1;
      chk("vec_empty_after", out_valid, 0);
    end

    // Stall: three back-to-back beats with out_ready low
    out_ready = 1'b0; co = 1'b0; a_msb = 1'b0; b_msb = 1'b0;
    in_valid = 1'b1; sum = 4'h1; step();
    chk("stall_acc1", accepted, 1);
    sum = 4'h2; step();
    chk("stall_acc2", accepted, 1);
    chk("stall_in_ready_low", in_ready, 0);
    sum = 4'h3; step();
    chk("stall_acc3_blocked", accepted, 0);
    chk("stall_hold_result", result, 4'h1);
    step();
    chk("stall_hold_result2", result, 4'h1);
    out_ready = 1'b1;
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 6) begin
      step();
      n++;
    end
    chk("stall_acc3_timeout", accepted, 1);
    drain(10);

    // Streaming: one result per cycle, in_ready never drops
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sum = 4'(i); co = 1'(i); a_msb = 1'(i >> 1); b_msb = 1'(i >> 2);
      step();
      chk("stream_in_ready", in_ready, 1);
      chk("stream_out_valid", out_valid, 1);
    end
    drain(10);

    // Mid-operation reset while FULL
    out_ready = 1'b0; in_valid = 1'b1;
    sum = 4'h1; step();
    sum = 4'h2; step();
    chk("full_before_rst", in_ready, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_result", result, 0);
    chk("midrst_flags", flags, 0);
    sb_q.delete();
    in_valid = 1'b0;
    @(posedge clk); #1;
    // Release together with a new beat: it must be taken on the first edge
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; sum = 4'h9; co = 1'b1;
    step();
    chk("post_rst_accept", accepted, 1);
    in_valid = 1'b0;
    repeat (3) step();
    chk("post_rst_empty", sb_q.size(), 0);

    // Random traffic against the reference queue
    verbose = 1'b0;
    max_depth = 0;
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      sum = 4'($urandom); co = 1'($urandom);
      a_msb = 1'($urandom); b_msb = 1'($urandom);
      step();
    end
    drain(10);
    chk("rand_max_depth", (max_depth <= 2), 1);
    $display("random run: max reference depth %0d", max_depth);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
